// File: rtl/decode_queue_if.sv
// Fetch-to-decode handshake bundle: fetch side drives valid/pc/inst, queue side drives ready.
interface decode_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;

    modport master (output valid, pc, inst, input ready);
    modport slave  (input valid, pc, inst, output ready);
endinterface

// File: rtl/decode_queue.sv
// Instruction queue feeding an RV32 decoder whose registered output bundle goes to EX.
// Load-use hazards against the bundle in EX are resolved locally by inserting a bubble.
module decode_queue #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DEPTH         = 4,
    parameter logic [6:0]  CUSTOM_OPCODE = 7'b0001011,
    parameter int unsigned ILLEGAL_CAUSE = 2,
    parameter int unsigned ECALL_CAUSE   = 11
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    decode_queue_if.slave            if_s,
    output logic [4:0]               rs1_addr_o,
    output logic [4:0]               rs2_addr_o,
    input  logic [XLEN-1:0]          reg_data1_i,
    input  logic [XLEN-1:0]          reg_data2_i,
    output logic                     ex_valid_o,
    input  logic                     ex_ready_i,
    output logic [XLEN-1:0]          ex_pc_o,
    output logic [XLEN-1:0]          ex_imm_o,
    output logic [XLEN-1:0]          ex_rs1_o,
    output logic [XLEN-1:0]          ex_rs2_o,
    output logic [4:0]               ex_rd_addr_o,
    output logic                     ex_rd_we_o,
    output logic [2:0]               ex_optype_o,
    output logic [2:0]               ex_funct3_o,
    output logic                     ex_mem_re_o,
    output logic                     ex_mem_we_o,
    output logic                     ex_ctx_o,
    output logic [XLEN-1:0]          ex_exception_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     hazard_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    typedef enum logic [2:0] {
        OPT_R     = 3'b000,
        OPT_I     = 3'b001,
        OPT_B     = 3'b010,
        OPT_S     = 3'b011,
        OPT_U     = 3'b100,
        OPT_M     = 3'b101,
        OPT_J     = 3'b110,
        OPT_OTHER = 3'b111
    } optype_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic            rd_we;
        optype_e         optype;
        logic [2:0]      funct3;
        logic            mem_re;
        logic            mem_we;
        logic            ctx;
        logic [XLEN-1:0] exc;
    } ex_bundle_t;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    ex_bundle_t      ex_q, ex_d;
    logic            ex_valid_q, ex_valid_d;

    logic            empty, adv, push, pop, hazard;
    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;

    logic [XLEN-1:0] dec_imm, dec_exc;
    optype_e         dec_optype;
    logic [2:0]      dec_funct3;
    logic            dec_wr, dec_re, dec_we, dec_ctx, use_rs1, use_rs2;

    assign inst   = inst_mem_q[rd_ptr_q];
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign empty       = (count_q == '0);
    assign if_s.ready  = (count_q < DEPTH_C);
    assign adv         = !ex_valid_q || ex_ready_i;
    assign push        = if_s.valid && if_s.ready && !flush_i;
    assign pop         = adv && !empty && !hazard && !flush_i;

    assign hazard = ex_valid_q && ex_q.mem_re && (ex_q.rd != 5'd0) && !empty &&
                    ((use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd)));

    always_comb begin
        dec_imm    = '0;
        dec_exc    = '0;
        dec_optype = OPT_OTHER;
        dec_funct3 = funct3;
        dec_wr     = 1'b0;
        dec_re     = 1'b0;
        dec_we     = 1'b0;
        dec_ctx    = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        // The custom opcode is checked first so it wins over any standard encoding it may alias.
        if (opcode == CUSTOM_OPCODE) begin
            dec_ctx = 1'b1;
            dec_wr  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec_optype = (inst[31:25] == 7'b0000001) ? OPT_M : OPT_R;
                    dec_wr     = 1'b1;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                OPC_OP_IMM, OPC_LOAD: begin
                    dec_optype = OPT_I;
                    dec_imm    = {{20{inst[31]}}, inst[31:20]};
                    dec_wr     = 1'b1;
                    dec_re     = (opcode == OPC_LOAD);
                    use_rs1    = 1'b1;
                end
                OPC_STORE: begin
                    dec_optype = OPT_S;
                    dec_imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    dec_we     = 1'b1;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                OPC_BRANCH: begin
                    dec_optype = OPT_B;
                    dec_imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_optype = OPT_U;
                    dec_imm    = {inst[31:12], 12'b0};
                    dec_funct3 = 3'b000;
                    dec_wr     = 1'b1;
                end
                OPC_JAL: begin
                    dec_optype = OPT_J;
                    dec_imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                    dec_wr     = 1'b1;
                end
                OPC_JALR: begin
                    dec_optype = OPT_J;
                    dec_imm    = {{20{inst[31]}}, inst[31:20]};
                    dec_wr     = 1'b1;
                    use_rs1    = 1'b1;
                end
                OPC_SYSTEM: begin
                    if (funct3 != 3'b000) begin
                        dec_imm = {27'b0, inst[19:15]};
                        dec_wr  = 1'b1;
                        use_rs1 = 1'b1;
                    end else if (inst == INST_ECALL) begin
                        dec_exc = XLEN'(ECALL_CAUSE);
                    end else if (inst == INST_MRET) begin
                        use_rs1 = 1'b1;
                    end
                end
                default: dec_exc = XLEN'(ILLEGAL_CAUSE);
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (adv) begin
            if (pop) begin
                ex_valid_d  = 1'b1;
                ex_d.pc     = pc_mem_q[rd_ptr_q];
                ex_d.imm    = dec_imm;
                ex_d.rs1    = reg_data1_i;
                ex_d.rs2    = reg_data2_i;
                ex_d.rd     = rd;
                ex_d.rd_we  = dec_wr && (rd != 5'd0);
                ex_d.optype = dec_optype;
                ex_d.funct3 = dec_funct3;
                ex_d.mem_re = dec_re;
                ex_d.mem_we = dec_we;
                ex_d.ctx    = dec_ctx;
                ex_d.exc    = dec_exc;
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= if_s.pc;
            inst_mem_q[wr_ptr_q] <= if_s.inst;
        end
    end

    assign rs1_addr_o     = rs1;
    assign rs2_addr_o     = rs2;
    assign hazard_o       = hazard;
    assign count_o        = count_q;
    assign ex_valid_o     = ex_valid_q;
    assign ex_pc_o        = ex_q.pc;
    assign ex_imm_o       = ex_q.imm;
    assign ex_rs1_o       = ex_q.rs1;
    assign ex_rs2_o       = ex_q.rs2;
    assign ex_rd_addr_o   = ex_q.rd;
    assign ex_rd_we_o     = ex_q.rd_we;
    assign ex_optype_o    = ex_q.optype;
    assign ex_funct3_o    = ex_q.funct3;
    assign ex_mem_re_o    = ex_q.mem_re;
    assign ex_mem_we_o    = ex_q.mem_we;
    assign ex_ctx_o       = ex_q.ctx;
    assign ex_exception_o = ex_q.exc;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues hand-decoded bundles, a negedge monitor
// compares every EX handshake against them; directed checks cover reset, fill, hazard and flush.
module tb_decode_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  opt;
        logic [2:0]  f3;
        logic        re;
        logic        mwe;
        logic        ctx;
        logic [31:0] exc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] reg_data1, reg_data2;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_exc;
    logic [4:0]  ex_rd;
    logic        ex_we, ex_re, ex_mwe, ex_ctx, hazard;
    logic [2:0]  ex_opt, ex_f3;
    logic [2:0]  count;

    bundle_t sb[$];
    bundle_t act_b, exp_b;
    int      n_vec = 0;
    int      n_err = 0;

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32)) fif ();

    // Regfile stand-in: each register reads as a tag plus its own index.
    assign reg_data1 = 32'hA000_0000 | {27'b0, rs1_addr};
    assign reg_data2 = 32'hB000_0000 | {27'b0, rs2_addr};

    decode_queue #(
        .XLEN(32),
        .DEPTH(4),
        .CUSTOM_OPCODE(7'b0001011),
        .ILLEGAL_CAUSE(2),
        .ECALL_CAUSE(11)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .if_s(fif.slave),
        .rs1_addr_o(rs1_addr),
        .rs2_addr_o(rs2_addr),
        .reg_data1_i(reg_data1),
        .reg_data2_i(reg_data2),
        .ex_valid_o(ex_valid),
        .ex_ready_i(ex_ready),
        .ex_pc_o(ex_pc),
        .ex_imm_o(ex_imm),
        .ex_rs1_o(ex_rs1),
        .ex_rs2_o(ex_rs2),
        .ex_rd_addr_o(ex_rd),
        .ex_rd_we_o(ex_we),
        .ex_optype_o(ex_opt),
        .ex_funct3_o(ex_f3),
        .ex_mem_re_o(ex_re),
        .ex_mem_we_o(ex_mwe),
        .ex_ctx_o(ex_ctx),
        .ex_exception_o(ex_exc),
        .count_o(count),
        .hazard_o(hazard)
    );

    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            act_b = {ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_we, ex_opt, ex_f3,
                     ex_re, ex_mwe, ex_ctx, ex_exc};
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_bundle pc=%h actual=%h required=<none>", ex_pc, act_b);
            end else begin
                exp_b = sb.pop_front();
                if (act_b !== exp_b) begin
                    n_err++;
                    $display("FAIL bundle pc=%h actual=%h required=%h", exp_b.pc, act_b, exp_b);
                end
            end
        end
    end

    function automatic bundle_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [4:0] rd, input logic we, input logic [2:0] opt,
                                   input logic [2:0] f3, input logic re, input logic mwe,
                                   input logic ctx, input logic [31:0] exc);
        mk = {pc, imm, r1, r2, rd, we, opt, f3, re, mwe, ctx, exc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge at which the instruction was taken.
    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input bit expect_out, input bundle_t exp);
        int tries = 0;
        fif.valid = 1'b1;
        fif.pc    = pc;
        fif.inst  = inst;
        while (!fif.ready && tries < 40) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!fif.ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout pc=%h actual=ready0 required=ready1", pc);
            fif.valid = 1'b0;
            return;
        end
        if (expect_out) sb.push_back(exp);
        @(posedge clk); #1;
        fif.valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int tries = 0;
        while ((sb.size() != 0 || count != 3'd0 || ex_valid) && tries < 60) begin
            @(posedge clk); #1;
            tries++;
        end
        n_vec++;
        if (sb.size() != 0 || count != 3'd0 || ex_valid) begin
            n_err++;
            $display("FAIL %s_drain actual=%0d_pending required=0_pending", name, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] inst;
        rst       = 1'b1;
        flush     = 1'b0;
        ex_ready  = 1'b1;
        fif.valid = 1'b0;
        fif.pc    = '0;
        fif.inst  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_if_ready", {31'b0, fif.ready}, 32'd1);
        check("rst_hazard", {31'b0, hazard}, 32'd0);
        check("rst_ex_pc", ex_pc, 32'd0);
        check("rst_ex_exc", ex_exc, 32'd0);

        // ADDI x1,x0,5: two-cycle latency from acceptance to valid bundle
        push(32'h100, 32'h0050_0093, 1'b1,
             mk(32'h100, 32'd5, 32'hA000_0000, 32'hB000_0005, 5'd1, 1'b1, 3'd1, 3'd0, 0, 0, 0, 32'd0));
        check("lat_cycle1_valid", {31'b0, ex_valid}, 32'd0);
        check("lat_cycle1_count", {29'b0, count}, 32'd1);
        @(posedge clk); #1;
        check("lat_cycle2_valid", {31'b0, ex_valid}, 32'd1);
        wait_drain("addi");

        // Fill with EX stalled: five ADDI x(i+1),x0,i all accepted
        ex_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            inst = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
            push(32'h200 + 32'(4 * i), inst, 1'b1,
                 mk(32'h200 + 32'(4 * i), 32'(i), 32'hA000_0000, 32'hB000_0000 | 32'(i),
                    5'(i + 1), 1'b1, 3'd1, 3'd0, 0, 0, 0, 32'd0));
        end
        check("full_count", {29'b0, count}, 32'd4);
        check("full_if_ready", {31'b0, fif.ready}, 32'd0);
        check("full_ex_valid", {31'b0, ex_valid}, 32'd1);
        fif.valid = 1'b1; fif.pc = 32'h2F0; fif.inst = 32'h0010_0093;
        @(posedge clk); #1;
        check("full_no_push", {29'b0, count}, 32'd4);
        ex_ready = 1'b1;
        @(posedge clk); #1;
        fif.valid = 1'b0;
        check("full_pop_no_bypass", {29'b0, count}, 32'd3);
        wait_drain("fill");

        // Load-use: LW x5,0(x2) then ADD x6,x5,x7 needs one bubble
        push(32'h300, 32'h0001_2283, 1'b1,
             mk(32'h300, 32'd0, 32'hA000_0002, 32'hB000_0000, 5'd5, 1'b1, 3'd1, 3'd2, 1, 0, 0, 32'd0));
        push(32'h304, 32'h0072_8333, 1'b1,
             mk(32'h304, 32'd0, 32'hA000_0005, 32'hB000_0007, 5'd6, 1'b1, 3'd0, 3'd0, 0, 0, 0, 32'd0));
        check("luse_hazard", {31'b0, hazard}, 32'd1);
        @(posedge clk); #1;
        check("luse_bubble_valid", {31'b0, ex_valid}, 32'd0);
        check("luse_bubble_hazard", {31'b0, hazard}, 32'd0);
        wait_drain("loaduse");

        // Load to x0 followed by x0 consumer: no bubble; ADDI x0 write suppressed
        push(32'h400, 32'h0001_2003, 1'b1,
             mk(32'h400, 32'd0, 32'hA000_0002, 32'hB000_0000, 5'd0, 1'b0, 3'd1, 3'd2, 1, 0, 0, 32'd0));
        push(32'h404, 32'h0000_0433, 1'b1,
             mk(32'h404, 32'd0, 32'hA000_0000, 32'hB000_0000, 5'd8, 1'b1, 3'd0, 3'd0, 0, 0, 0, 32'd0));
        check("x0_no_hazard", {31'b0, hazard}, 32'd0);
        @(posedge clk); #1;
        check("x0_no_bubble", {31'b0, ex_valid}, 32'd1);
        push(32'h408, 32'h0010_0013, 1'b1,
             mk(32'h408, 32'd1, 32'hA000_0000, 32'hB000_0001, 5'd0, 1'b0, 3'd1, 3'd0, 0, 0, 0, 32'd0));
        wait_drain("x0");

        // Decode classes: illegal, ECALL, CTX, SW, LUI, BEQ, JAL
        push(32'h500, 32'h0000_037F, 1'b1,
             mk(32'h500, 32'd0, 32'hA000_0000, 32'hB000_0000, 5'd6, 1'b0, 3'd7, 3'd0, 0, 0, 0, 32'd2));
        push(32'h504, 32'h0000_0073, 1'b1,
             mk(32'h504, 32'd0, 32'hA000_0000, 32'hB000_0000, 5'd0, 1'b0, 3'd7, 3'd0, 0, 0, 0, 32'd11));
        push(32'h508, 32'h0041_948B, 1'b1,
             mk(32'h508, 32'd0, 32'hA000_0003, 32'hB000_0004, 5'd9, 1'b1, 3'd7, 3'd1, 0, 0, 1, 32'd0));
        push(32'h50C, 32'h0071_2623, 1'b1,
             mk(32'h50C, 32'd12, 32'hA000_0002, 32'hB000_0007, 5'd12, 1'b0, 3'd3, 3'd2, 0, 1, 0, 32'd0));
        push(32'h510, 32'h1234_5537, 1'b1,
             mk(32'h510, 32'h1234_5000, 32'hA000_0008, 32'hB000_0003, 5'd10, 1'b1, 3'd4, 3'd0, 0, 0, 0, 32'd0));
        push(32'h514, 32'hFE20_8CE3, 1'b1,
             mk(32'h514, 32'hFFFF_FFF8, 32'hA000_0001, 32'hB000_0002, 5'd25, 1'b0, 3'd2, 3'd0, 0, 0, 0, 32'd0));
        push(32'h518, 32'h0100_00EF, 1'b1,
             mk(32'h518, 32'd16, 32'hA000_0000, 32'hB000_0010, 5'd1, 1'b1, 3'd6, 3'd0, 0, 0, 0, 32'd0));
        wait_drain("classes");

        // Flush with three queued, one in EX, and a concurrent push: none may emerge
        ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h600 + 32'(4 * i), 32'h0010_0093, 1'b0, '0);
        end
        check("preflush_count", {29'b0, count}, 32'd3);
        fif.valid = 1'b1; fif.pc = 32'h6F0; fif.inst = 32'h0030_0193;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fif.valid = 1'b0;
        check("flush_count", {29'b0, count}, 32'd0);
        check("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_ex_pc", ex_pc, 32'd0);
        ex_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("postflush_count", {29'b0, count}, 32'd0);
        check("postflush_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register ID stage.
- A DEPTH-entry instruction queue decouples fetch from decode, with valid/ready handshakes on both sides.
- The queue head is decoded into a registered EX-bound bundle. Load-use interlock is internal: a bubble is inserted instead of exporting a hazard flag to pipe control.
- Adds a configurable custom opcode, illegal-instruction detection, and rd=x0 write suppression.

Parameters:
XLEN, 32, datapath width; decode semantics are RV32 and only XLEN=32 is supported.
DEPTH, 4, queue entries; power of two, minimum 2.
CUSTOM_OPCODE, 7'b0001011, opcode decoded as the CTX custom instruction.
ILLEGAL_CAUSE, 2, exception code for an unrecognised opcode.
ECALL_CAUSE, 11, exception code for ECALL (M-mode).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard queue and output bundle
if_valid_i  in  1  fetch offers an instruction
if_pc_i  in  XLEN  pc of offered instruction
if_inst_i  in  32  offered instruction
if_ready_o  out  1  queue can accept (count < DEPTH)
rs1_addr_o  out  5  head inst[19:15], to regfile (combinational)
rs2_addr_o  out  5  head inst[24:20], to regfile (combinational)
reg_data1_i  in  XLEN  regfile read data 1
reg_data2_i  in  XLEN  regfile read data 2
ex_valid_o  out  1  output bundle valid
ex_ready_i  in  1  EX accepts bundle
ex_pc_o  out  XLEN  pc
ex_imm_o  out  XLEN  decoded immediate
ex_rs1_o  out  XLEN  captured operand 1
ex_rs2_o  out  XLEN  captured operand 2
ex_rd_addr_o  out  5  destination register
ex_rd_we_o  out  1  register write enable
ex_optype_o  out  3  instruction class
ex_funct3_o  out  3  funct3; 0 for LUI/AUIPC
ex_mem_re_o  out  1  load
ex_mem_we_o  out  1  store
ex_ctx_o  out  1  custom CTX instruction
ex_exception_o  out  XLEN  exception cause; 0 when none
count_o  out  clog2(DEPTH)+1  queue occupancy
hazard_o  out  1  load-use bubble being inserted this cycle

Behaviour:
Reset and flush:
- rst_i or flush_i at an edge: count, read and write pointers go to 0, and ex_valid_o goes to 0.
- All ex_* data outputs go to 0, and hazard_o reads 0.
- Flush dominates a push or pop in the same cycle; the offered instruction is dropped.

Queue:
- Push when if_valid_i && if_ready_o. if_ready_o = (count < DEPTH), derived from registered count.
- There is no full-bypass: no push while full, even when popping in the same cycle.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves count unchanged.
- There is no empty-bypass: latency from an accepted push to ex_valid_o=1 is 2 cycles when the queue is empty and EX is ready.

Output advance:
- adv = !ex_valid_o || ex_ready_i.
- On adv with the queue non-empty and no hazard: decode the head into the ex_* registers, set ex_valid_o=1, and pop.
- On adv with the queue empty: ex_valid_o=0 and the data registers hold.
- When !adv: all outputs hold (stall).

Decode classes:
- ex_optype_o encoding: R=000, I=001, B=010, S=011, LUI/AUIPC=100, M(funct7=0000001 on 0110011)=101, JAL/JALR=110, other=111.
- Immediates are I/L/S/U/J/B/CSR-zimm per RV32; zimm = zero-extended inst[19:15]. All other classes give imm=0.
- Register writes apply to I, R, M, load, LUI, AUIPC, JAL, JALR, CSR and CTX. ex_rd_we_o is forced to 0 when rd=0.
- ex_mem_re_o is set for opcode 0000011; ex_mem_we_o for 0100011.
- ex_ctx_o is set for CUSTOM_OPCODE.
- Exceptions: ECALL (0x00000073) gives ECALL_CAUSE. Any opcode outside the recognised set gives ILLEGAL_CAUSE with ex_rd_we_o, ex_mem_re_o and ex_mem_we_o all 0. Otherwise 0.

Load-use hazard:
- hazard = ex_valid_o && ex_mem_re_o && ex_rd_addr_o!=0 && queue non-empty, and the head uses rs1 (R/M/I/L/S/B/JALR/CSR/CTX/MRET) with rs1==ex_rd_addr_o, or uses rs2 (R/M/S/B/CTX) with rs2==ex_rd_addr_o.
- hazard_o = hazard, combinational.
- On adv with hazard: ex_valid_o goes to 0 (bubble) and the head is not popped. The next adv decodes it normally.

Test Plan:
- Reset, then push ADDI x1,x0,5 (0x00500093) at pc 0x100 with ex_ready_i=1 -> ex_valid_o=1 two cycles later; ex_imm_o=5, ex_rd_addr_o=1, ex_rd_we_o=1, ex_optype_o=001, ex_pc_o=0x100.
- Push 5 instructions back-to-back with ex_ready_i=0, DEPTH=4 -> 4 accepted, if_ready_o=0 and count_o=4 after the queue fills (the first decoded sits in ex_*, so count drops to 3 and a 5th is accepted). Then release ex_ready_i -> all 5 emerge in pc order.
- LW x5,0(x2) followed by ADD x6,x5,x7 -> one cycle with hazard_o=1 and ex_valid_o=0 between them; ADD then emitted with ex_rd_addr_o=6.
- Load to x0 followed by a consumer of x0 -> no bubble. ADDI x0,x0,1 -> ex_rd_we_o=0.
- Opcode 0x7F -> ex_exception_o=2 and ex_rd_we_o=0. ECALL -> ex_exception_o=11. CUSTOM_OPCODE instruction -> ex_ctx_o=1 and ex_rd_we_o=1.
- flush_i asserted with 3 entries queued and a concurrent push -> next cycle count_o=0 and ex_valid_o=0; the pushed instruction never appears.
